// File: rtl/difftest_pkg.sv
// Shared encodings for the DiffTest commit-side controller.
package difftest_pkg;

    typedef enum logic [1:0] {
        HALT_NONE    = 2'b00,
        HALT_EBREAK  = 2'b01,
        HALT_TIMEOUT = 2'b10
    } halt_reason_e;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } ctrl_state_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/commit_watchdog.sv
// No-commit watchdog: pulses expired in the last idle cycle before the limit.
module commit_watchdog
    import difftest_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    if (TIMEOUT_CYCLES == 0) begin : g_off
        assign expired = 1'b0;
    end else begin : g_on
        localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

        logic [CW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (enable) begin
                cnt_d = kick ? '0 : cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        // A commit in the final cycle beats the timeout.
        assign expired = enable && !kick && (cnt_q == LAST);
    end

endmodule

// File: rtl/difftest_commit_ctrl.sv
// Delays the retire strobe one cycle into the DiffTest enable, tracks halt
// (ebreak / watchdog) and keeps instret / cycle counters.
module difftest_commit_ctrl
    import difftest_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             commit_valid,
    input  logic [31:0]      commit_pc,
    input  logic             commit_mmio,
    input  logic             commit_ebreak,
    input  logic [31:0]      a0_value,
    output logic             dt_enable,
    output logic [31:0]      dt_pc,
    output logic             dt_skip,
    output logic             halted,
    output logic [1:0]       halt_reason,
    output logic [31:0]      halt_code,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] cycles
);

    ctrl_state_e      state_q, state_d;
    halt_reason_e     reason_q, reason_d;
    logic             en_q, en_d;
    logic [31:0]      pc_q, pc_d;
    logic             skip_q, skip_d;
    logic [31:0]      code_q, code_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             wd_expired;

    commit_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .enable (state_q == RUN),
        .kick   (commit_valid),
        .expired(wd_expired)
    );

    // The fire stage is the latch: the commit registered at the retire edge
    // is the dt_* output of the following cycle, so GPR/CSR state already matches.
    always_comb begin
        state_d   = state_q;
        reason_d  = reason_q;
        en_d      = 1'b0;
        pc_d      = pc_q;
        skip_d    = 1'b0;
        code_d    = code_q;
        instret_d = instret_q;
        cycles_d  = cycles_q;
        if (state_q == RUN) begin
            cycles_d = cycles_q + 1'b1;
            if (commit_valid) begin
                en_d      = 1'b1;
                pc_d      = commit_pc;
                skip_d    = commit_mmio;
                instret_d = instret_q + 1'b1;
                if (commit_ebreak) begin
                    state_d  = HALTED;
                    reason_d = HALT_EBREAK;
                    code_d   = a0_value;
                end
            end else if (wd_expired) begin
                state_d  = HALTED;
                reason_d = HALT_TIMEOUT;
                code_d   = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            reason_q  <= HALT_NONE;
            en_q      <= 1'b0;
            pc_q      <= '0;
            skip_q    <= 1'b0;
            code_q    <= '0;
            instret_q <= '0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            reason_q  <= reason_d;
            en_q      <= en_d;
            pc_q      <= pc_d;
            skip_q    <= skip_d;
            code_q    <= code_d;
            instret_q <= instret_d;
            cycles_q  <= cycles_d;
        end
    end

    assign dt_enable   = en_q;
    assign dt_pc       = pc_q;
    assign dt_skip     = skip_q;
    assign halted      = (state_q == HALTED);
    assign halt_reason = reason_q;
    assign halt_code   = code_q;
    assign instret     = instret_q;
    assign cycles      = cycles_q;

endmodule

// File: doc/difftest_commit_ctrl.md
Name: difftest_commit_ctrl

Overview:
Commit-side controller that sits directly upstream of the DiffTest DPI signal block. It converts the core's write-back "instruction retired" strobe into a one-cycle-delayed difftest enable, so the live GPR/CSR values seen downstream already include the retiring instruction's write. It also tags MMIO commits for ref-skip, detects ebreak halt, runs a no-commit watchdog, and keeps instret/cycle counters for the simulation harness.

Parameters:
TIMEOUT_CYCLES, 1000000, cycles without a commit before timeout halt; 0 disables the watchdog
CNT_W, 64, width of instret and cycles counters

Ports:
clock  in  1  core clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
commit_valid  in  1  one-cycle pulse: instruction retires this cycle; its regfile/CSR write lands at this edge
commit_pc  in  32  PC of the retiring instruction
commit_mmio  in  1  retiring instruction accessed MMIO; ref must skip it
commit_ebreak  in  1  retiring instruction is ebreak
a0_value  in  32  live GPR x10
dt_enable  out  1  to DiffTest DPI enable; one-cycle pulse per commit
dt_pc  out  32  PC paired with dt_enable
dt_skip  out  1  qualifies dt_enable; 1 = skip ref step
halted  out  1  sticky; simulation finished
halt_reason  out  2  00 none, 01 ebreak, 10 timeout
halt_code  out  32  a0 captured at ebreak fire
instret  out  CNT_W  retired-instruction count
cycles  out  CNT_W  cycles since reset, frozen at halt

Behaviour:
- Reset (async, any time): dt_enable=0, dt_pc=0, dt_skip=0, halted=0, halt_reason=00, halt_code=0, instret=0, cycles=0, watchdog=0, state=RUN. Any commit latched but not yet fired is dropped.
- States: RUN, HALTED. HALTED is left only by reset.
- Commit in RUN:
  - commit_valid=1 in cycle t: latch pc, mmio and ebreak.
  - Cycle t+1: dt_enable=1, dt_pc=latched pc, dt_skip=latched mmio.
  - Fixed latency 1; all outputs are registered.
  - Back-to-back commits (t, t+1, ...) yield back-to-back pulses with no loss and no buffering beyond the one stage.
- instret increments at the edge ending cycle t, visible in t+1 together with dt_enable. MMIO commits count.
- ebreak commit at t:
  - dt_enable fires at t+1 as usual.
  - In the same t+1: halted=1, halt_reason=01, halt_code=a0_value sampled at the edge ending t. This captures a0 as written by the preceding instruction; ebreak itself writes no GPR.
  - state becomes HALTED.
- HALTED:
  - commit_valid is ignored: no dt_enable, instret and cycles frozen, watchdog frozen.
  - The ebreak's own pending fire still completes, since it is issued at the same edge.
- cycles increments every cycle in RUN and wraps modulo 2^CNT_W. instret also wraps.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter clears on commit_valid and increments otherwise.
  - When the counter equals TIMEOUT_CYCLES-1 and commit_valid=0: next cycle halted=1, halt_reason=10, halt_code=0.
  - commit_valid in that same cycle wins: counter clears, no timeout.
- commit_ebreak or commit_mmio while commit_valid=0: ignored.

Decomposition:
- Shared package difftest_pkg: halt_reason encodings (HALT_NONE=2'b00, HALT_EBREAK=2'b01, HALT_TIMEOUT=2'b10), RUN/HALTED state enum, default TIMEOUT_CYCLES.
- One sub-module, commit_watchdog:
  - Parameter TIMEOUT_CYCLES; inputs clock, reset, enable (state==RUN), kick (commit_valid); output expired pulse.
  - Counter width is ceil(log2(TIMEOUT_CYCLES+1)).
  - Generates constant expired=0 when TIMEOUT_CYCLES=0.
- Counters and fire stage stay in the top.

Test Plan:
- Reset, commit at cycles 3, 4, 5 with pc 0x80000000/04/08 -> dt_enable high in cycles 4, 5, 6 with matching dt_pc; instret = 1, 2, 3 in those cycles.
- Commit pc 0xa00003f8 with commit_mmio=1 -> next cycle dt_enable=1, dt_skip=1; following non-MMIO commit has dt_skip=0.
- a0_value=0 before cycle 10, ebreak commit at 10 -> cycle 11: dt_enable=1, halted=1, halt_reason=01, halt_code=0; commits at 11..15 produce no dt_enable; instret and cycles frozen.
- TIMEOUT_CYCLES=8, last commit at cycle 2 -> halted=1, halt_reason=10 at cycle 11; variant with a commit in cycle 10 -> no timeout, dt_enable at 11.
- Commit at cycle 5, async reset asserted mid-cycle 5 and released in 6 -> no dt_enable at 6; all outputs 0 immediately on reset assertion.
- CNT_W=4, 17 back-to-back commits -> instret wraps to 0 after 16, then reads 1; dt_enable never drops.
